ldtu_decoder: RTL and testbench

Receive-side unpacker for the LiTe-DTU 32-bit encoded word stream. It accepts each 32-bit word with its load strobe and decodes the word type: baseline full, baseline partial, signal pair, signal sync, orbit header, or fallback pair. It then serializes the packed samples back into a one-sample-per-cycle 13-bit stream with type, orbit and error flags. It sits in the back-end/test-bench emulation path behind the serializer deframer, and is the inverse of the LiTe-DTU encoder.

---
 rtl/ldtu_decoder.sv | 175 +++++++++++++++++
 tb/tb_ldtu_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_decoder.sv
// ldtu_decoder: unpacks LiTe-DTU 32-bit encoded words into a one-sample-per-cycle 13-bit stream.
// Define LDTU_DEC_PARITY_CHECK_EN to check the parity bits of fallback words.
module ldtu_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK_,
  input  logic        reset_,
  input  logic        fallback_,
  input  logic [31:0] DATA_32,
  input  logic        Load,
  output logic [12:0] Sample,
  output logic        Sample_valid,
  output logic        Sample_bas,
  output logic        Orbit_flag,
  output logic        Parity_err,
  output logic        Format_err,
  output logic        Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [12:0] SYNC_PAT  = 13'b0101010101010;
  localparam logic [12:0] ORBIT_PAT = 13'b1111000001111;

  typedef enum logic [1:0] {IDLE, DECODE, EMIT} state_t;
  typedef enum logic [2:0] {K_ERR, K_BAS, K_SIG, K_ORB, K_FB} kind_t;

  logic [32:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop, last_out;

  state_t      state;
  kind_t       kind, cls_kind, cur_kind;
  logic [31:0] word;
  logic        word_fb;
  logic [2:0]  n_cnt, idx, cls_n, cur_idx;
  logic [12:0] cur_sample;
  logic        parity_bad;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // The edge that registers a word's final sample (or its error pulse) also fetches the next word.
  assign last_out = (state == DECODE && cls_n <= 3'd1) ||
                    (state == EMIT && idx == n_cnt - 3'd1);
  assign pop      = !empty && (state == IDLE || last_out);
  assign push     = Load && (!full || pop);

  always_ff @(posedge CLK_) begin
    if (!reset_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[AW-1:0]] <= {fallback_, DATA_32};
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      Overflow <= Load && full && !pop;
    end
  end

  always_comb begin
    cls_kind = K_ERR;
    cls_n    = 3'd0;
    if (word_fb) begin
      if (word[31:28] == 4'hF) begin
        cls_kind = K_FB;
        cls_n    = 3'd2;
      end
    end else begin
      case (word[31:30])
        2'b01: begin
          cls_kind = K_BAS;
          cls_n    = 3'd5;
        end
        2'b10: begin
          if (word[29:24] >= 6'd1 && word[29:24] <= 6'd4) begin
            cls_kind = K_BAS;
            cls_n    = word[26:24];
          end
        end
        2'b00: begin
          if (word[29:26] == 4'b1010) begin
            cls_kind = K_SIG;
            cls_n    = 3'd2;
          end else if (word[29:26] == 4'b1011 && word[25:13] == SYNC_PAT) begin
            cls_kind = K_SIG;
            cls_n    = 3'd1;
          end else if (word[29:26] == 4'b1011 && word[25:13] == ORBIT_PAT) begin
            cls_kind = K_ORB;
            cls_n    = 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // DECODE already emits sample 0, so the first sample leaves three cycles after Load.
  always_comb begin
    cur_idx    = (state == DECODE) ? 3'd0 : idx;
    cur_kind   = (state == DECODE) ? cls_kind : kind;
    cur_sample = '0;
    if (cur_kind == K_BAS) begin
      case (cur_idx)
        3'd0:    cur_sample = {7'd0, word[5:0]};
        3'd1:    cur_sample = {7'd0, word[11:6]};
        3'd2:    cur_sample = {7'd0, word[17:12]};
        3'd3:    cur_sample = {7'd0, word[23:18]};
        default: cur_sample = {7'd0, word[29:24]};
      endcase
    end else begin
      cur_sample = cur_idx[0] ? word[25:13] : word[12:0];
    end
  end

`ifdef LDTU_DEC_PARITY_CHECK_EN
  assign parity_bad = (cur_kind == K_FB) &&
                      (cur_idx[0] ? (word[27] != ~^word[25:13]) : (word[26] != ~^word[12:0]));
`else
  assign parity_bad = 1'b0;
`endif

  always_ff @(posedge CLK_) begin
    if (!reset_) begin
      state        <= IDLE;
      kind         <= K_ERR;
      word         <= '0;
      word_fb      <= 1'b0;
      n_cnt        <= '0;
      idx          <= '0;
      Sample       <= '0;
      Sample_valid <= 1'b0;
      Sample_bas   <= 1'b0;
      Orbit_flag   <= 1'b0;
      Parity_err   <= 1'b0;
      Format_err   <= 1'b0;
    end else begin
      Sample       <= '0;
      Sample_valid <= 1'b0;
      Sample_bas   <= 1'b0;
      Orbit_flag   <= 1'b0;
      Parity_err   <= 1'b0;
      Format_err   <= 1'b0;
      if (pop) begin
        word    <= fifo_mem[rd_ptr[AW-1:0]][31:0];
        word_fb <= fifo_mem[rd_ptr[AW-1:0]][32];
      end
      if ((state == DECODE && cls_kind != K_ERR) || state == EMIT) begin
        Sample       <= cur_sample;
        Sample_valid <= 1'b1;
        Sample_bas   <= (cur_kind == K_BAS);
        Orbit_flag   <= (cur_kind == K_ORB);
        Parity_err   <= parity_bad;
      end
      case (state)
        IDLE: if (pop) state <= DECODE;
        DECODE: begin
          kind       <= cls_kind;
          n_cnt      <= cls_n;
          idx        <= 3'd1;
          Format_err <= (cls_kind == K_ERR);
          if (cls_n > 3'd1) state <= EMIT;
          else              state <= pop ? DECODE : IDLE;
        end
        EMIT: begin
          idx <= idx + 3'd1;
          if (last_out) state <= pop ? DECODE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldtu_decoder.sv
// tb_ldtu_decoder: directed literal checks plus randomized traffic against a slot-timing reference model.
module tb_ldtu_decoder;

  localparam int DEPTH = 4;
`ifdef LDTU_DEC_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [31:0] W_BASE = {2'b01, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
  localparam logic [31:0] W_PART = {2'b10, 6'd2, 12'd0, 6'd9, 6'd7};
  localparam logic [31:0] W_PAIR = {6'b001010, 13'h1ABC, 13'h0123};
  localparam logic [31:0] W_ORB  = {6'b001011, 13'b1111000001111, 13'h0055};
  localparam logic [31:0] W_SYNC = {6'b001011, 13'b0101010101010, 13'h0055};
  localparam logic [31:0] W_FB   = {4'hF, 1'b1, 1'b1, 13'h0003, 13'h0001};

  logic        CLK_ = 1'b0;
  logic        reset_, fallback_, Load;
  logic [31:0] DATA_32;
  logic [12:0] Sample;
  logic        Sample_valid, Sample_bas, Orbit_flag, Parity_err, Format_err, Overflow;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [12:0] s;
    bit valid, bas, orb, par, fmt;
  } exp_t;

  exp_t exp_map [int];
  bit   ovf_map [int];
  int   pend_pop [$];
  int   last_end = 0;
  exp_t wq [$];

  ldtu_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK_(CLK_), .reset_(reset_), .fallback_(fallback_), .DATA_32(DATA_32), .Load(Load),
    .Sample(Sample), .Sample_valid(Sample_valid), .Sample_bas(Sample_bas),
    .Orbit_flag(Orbit_flag), .Parity_err(Parity_err), .Format_err(Format_err),
    .Overflow(Overflow)
  );

  always #5 CLK_ = ~CLK_;
  always @(posedge CLK_) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, want);
    end
  endtask

  function automatic exp_t mkExp(input logic [12:0] s, input bit v, input bit bas,
                                 input bit orb, input bit par, input bit fmt);
    exp_t e;
    e.s = s; e.valid = v; e.bas = bas; e.orb = orb; e.par = par; e.fmt = fmt;
    return e;
  endfunction

  function automatic bit evenOnes(input logic [12:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  // Expected output slots of one word, straight from the word-format rules.
  function automatic void modelWord(input bit fb, input logic [31:0] d);
    int n;
    wq.delete();
    n = int'(d[29:24]);
    if (fb) begin
      if (d[31:28] == 4'hF) begin
        wq.push_back(mkExp(d[12:0], 1, 0, 0, PAR_EN && (d[26] != evenOnes(d[12:0])), 0));
        wq.push_back(mkExp(d[25:13], 1, 0, 0, PAR_EN && (d[27] != evenOnes(d[25:13])), 0));
      end else wq.push_back(mkExp(13'd0, 0, 0, 0, 0, 1));
    end else if (d[31:30] == 2'b01 || (d[31:30] == 2'b10 && n >= 1 && n <= 4)) begin
      if (d[31:30] == 2'b01) n = 5;
      for (int i = 0; i < n; i++) wq.push_back(mkExp(13'((d >> (6*i)) & 32'h3F), 1, 1, 0, 0, 0));
    end else if (d[31:26] == 6'b001010) begin
      wq.push_back(mkExp(d[12:0], 1, 0, 0, 0, 0));
      wq.push_back(mkExp(d[25:13], 1, 0, 0, 0, 0));
    end else if (d[31:26] == 6'b001011 && d[25:13] == 13'h0AAA) begin
      wq.push_back(mkExp(d[12:0], 1, 0, 0, 0, 0));
    end else if (d[31:26] == 6'b001011 && d[25:13] == 13'h1E0F) begin
      wq.push_back(mkExp(d[12:0], 1, 0, 1, 0, 0));
    end else wq.push_back(mkExp(13'd0, 0, 0, 0, 0, 1));
  endfunction

  // Words occupy consecutive output slots: start = max(load+3, previous end+1), popped two cycles before.
  always @(negedge CLK_) begin
    exp_t e;
    int s, cnt;
    bit pop_now;
    if (exp_map.exists(cyc)) begin
      e = exp_map[cyc];
      exp_map.delete(cyc);
    end else e = mkExp(13'd0, 0, 0, 0, 0, 0);
    checkOutput("valid", Sample_valid, e.valid);
    if (e.valid) checkOutput("sample", Sample, e.s);
    checkOutput("bas", Sample_bas, e.bas);
    checkOutput("orbit", Orbit_flag, e.orb);
    checkOutput("parity", Parity_err, e.par);
    checkOutput("format", Format_err, e.fmt);
    checkOutput("overflow", Overflow, ovf_map.exists(cyc));
    if (ovf_map.exists(cyc)) ovf_map.delete(cyc);
    if (!reset_) begin
      exp_map.delete();
      ovf_map.delete();
      pend_pop.delete();
      last_end = cyc;
    end else begin
      while (pend_pop.size() > 0 && pend_pop[0] < cyc) void'(pend_pop.pop_front());
      cnt = pend_pop.size();
      pop_now = (cnt > 0) && (pend_pop[0] == cyc);
      if (Load) begin
        if (cnt < DEPTH || pop_now) begin
          modelWord(fallback_, DATA_32);
          s = (cyc + 3 > last_end + 1) ? cyc + 3 : last_end + 1;
          foreach (wq[i]) exp_map[s + i] = wq[i];
          last_end = s + wq.size() - 1;
          pend_pop.push_back(s - 2);
        end else ovf_map[cyc + 1] = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input bit ld, input bit fb, input logic [31:0] d, input bit rst_n);
    @(posedge CLK_);
    #1;
    Load = ld;
    fallback_ = fb;
    DATA_32 = d;
    reset_ = rst_n;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 32'd0, 1);
  endtask

  task automatic gotoNeg(input int t);
    repeat (t - cyc) @(posedge CLK_);
    @(negedge CLK_);
  endtask

  task automatic atCycle(input int t);
    repeat (t - cyc) @(posedge CLK_);
    #1;
  endtask

  function automatic void genWord(output bit fb, output logic [31:0] d);
    int k;
    logic [31:0] r;
    k = $urandom_range(0, 7);
    r = $urandom;
    fb = 1'b0;
    case (k)
      0: d = {2'b01, r[29:0]};
      1: d = {2'b10, 6'($urandom_range(0, 5)), r[23:0]};
      2: d = {6'b001010, r[25:0]};
      3: d = {6'b001011, 13'h0AAA, r[12:0]};
      4: d = {6'b001011, 13'h1E0F, r[12:0]};
      5: d = r;
      6: begin fb = 1'b1; d = {4'hF, r[27:0]}; end
      default: begin fb = 1'b1; d = r; end
    endcase
  endfunction

  initial begin
    int n;
    bit fb;
    logic [31:0] d;
    reset_ = 1'b0; Load = 1'b0; fallback_ = 1'b0; DATA_32 = '0;
    repeat (3) applyStimulus(0, 0, 32'd0, 0);
    gotoNeg(cyc);
    checkOutput("rst_sample", Sample, 0);
    checkOutput("rst_valid", Sample_valid, 0);
    checkOutput("rst_ovf", Overflow, 0);
    idle(2);

    applyStimulus(1, 0, W_BASE, 1); n = cyc; idle(1);
    gotoNeg(n + 2); checkOutput("base_lat", Sample_valid, 0);
    for (int i = 0; i < 5; i++) begin
      gotoNeg(n + 3 + i);
      checkOutput("base_sample", Sample, i + 1);
      checkOutput("base_bas", Sample_bas, 1);
    end
    gotoNeg(n + 8); checkOutput("base_end", Sample_valid, 0);
    idle(3);

    applyStimulus(1, 0, W_PART, 1); n = cyc; applyStimulus(1, 0, W_PAIR, 1); idle(1);
    gotoNeg(n + 3); checkOutput("part_s0", Sample, 13'd7);  checkOutput("part_bas", Sample_bas, 1);
    gotoNeg(n + 4); checkOutput("part_s1", Sample, 13'd9);
    gotoNeg(n + 5); checkOutput("pair_s0", Sample, 13'h0123); checkOutput("pair_bas", Sample_bas, 0);
    gotoNeg(n + 6); checkOutput("pair_s1", Sample, 13'h1ABC); checkOutput("pair_v", Sample_valid, 1);
    idle(3);

    applyStimulus(1, 0, W_ORB, 1); n = cyc; applyStimulus(1, 0, W_SYNC, 1); idle(1);
    gotoNeg(n + 3); checkOutput("orb_s", Sample, 13'h0055); checkOutput("orb_flag", Orbit_flag, 1);
    gotoNeg(n + 4); checkOutput("sync_s", Sample, 13'h0055); checkOutput("sync_flag", Orbit_flag, 0);
    idle(3);

    applyStimulus(1, 0, 32'hF000_0000, 1); n = cyc; idle(1);
    gotoNeg(n + 2); checkOutput("fmt_pre", Format_err, 0);
    gotoNeg(n + 3); checkOutput("fmt_err", Format_err, 1); checkOutput("fmt_valid", Sample_valid, 0);
    gotoNeg(n + 4); checkOutput("fmt_post", Format_err, 0);
    idle(3);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, W_BASE, 1);
      if (i == 0) n = cyc;
    end
    gotoNeg(n + 5); checkOutput("ovf_pre", Overflow, 0);
    applyStimulus(1, 0, W_PAIR, 1);
    gotoNeg(n + 6); checkOutput("ovf_hit", Overflow, 1);
    idle(1);
    gotoNeg(n + 7); checkOutput("ovf_pushpop", Overflow, 0);
    idle(40);

    applyStimulus(1, 1, W_FB, 1); n = cyc; idle(1);
    gotoNeg(n + 3); checkOutput("fb_s0", Sample, 13'h0001); checkOutput("fb_par0", Parity_err, PAR_EN);
    gotoNeg(n + 4); checkOutput("fb_s1", Sample, 13'h0003); checkOutput("fb_par1", Parity_err, 0);
    idle(3);

    applyStimulus(1, 0, W_BASE, 1); n = cyc; applyStimulus(1, 0, W_PAIR, 1); idle(1);
    gotoNeg(n + 3); checkOutput("rmid_s0", Sample, 13'd1);
    atCycle(n + 5); reset_ = 1'b0;
    @(negedge CLK_); checkOutput("rmid_s2", Sample, 13'd3);
    atCycle(n + 6); reset_ = 1'b1;
    @(negedge CLK_);
    checkOutput("rmid_sample", Sample, 0);
    checkOutput("rmid_valid", Sample_valid, 0);
    checkOutput("rmid_bas", Sample_bas, 0);
    applyStimulus(1, 0, W_BASE, 1); n = cyc; idle(1);
    gotoNeg(n + 2); checkOutput("rrel_lat", Sample_valid, 0);
    gotoNeg(n + 3); checkOutput("rrel_s0", Sample, 13'd1); checkOutput("rrel_v", Sample_valid, 1);
    idle(12);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, {2'b01, 30'($urandom)}, 1);
      idle(4);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, {6'b001010, 26'($urandom)}, 1);
      idle(1);
    end
    idle(10);

    for (int i = 0; i < 3000; i++) begin
      genWord(fb, d);
      applyStimulus($urandom_range(0, 99) < 45, fb, d, $urandom_range(0, 199) != 0);
    end
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
